// File: rtl/vend_controller.sv
// Vending transaction sequencer: accumulates coin credit, vends priced items,
// and hands any change to the coin dispenser with a completion timeout.
module vend_controller #(
  parameter int PRICE0     = 65,
  parameter int PRICE1     = 100,
  parameter int PRICE2     = 125,
  parameter int PRICE3     = 150,
  parameter int MAX_CREDIT = 500,
  parameter int TIMEOUT    = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_q,
  input  logic       coin_d,
  input  logic       coin_n,
  input  logic       sel_valid,
  input  logic [1:0] sel_item,
  input  logic       cancel,
  input  logic       disp_busy,
  input  logic       disp_done,
  output logic       disp,
  output logic [9:0] change,
  output logic [9:0] credit,
  output logic       vend,
  output logic [1:0] vend_item,
  output logic       no_funds,
  output logic       coin_reject,
  output logic       busy,
  output logic       txn_done,
  output logic       fault
);

  typedef enum logic [1:0] {ACCEPT, CHG_REQ, CHG_WAIT} state_t;

  state_t     state_q, state_d;
  logic [9:0] credit_q, credit_d;
  logic [9:0] change_amt_q, change_amt_d;
  logic [7:0] timer_q, timer_d;
  logic [9:0] change_q, change_d;
  logic       disp_q, disp_d;
  logic       vend_q, vend_d;
  logic [1:0] vend_item_q, vend_item_d;
  logic       no_funds_q, no_funds_d;
  logic       coin_reject_q, coin_reject_d;
  logic       busy_q, busy_d;
  logic       txn_done_q, txn_done_d;
  logic       fault_q, fault_d;

  logic [1:0]  coin_count;
  logic        coin_any;
  logic [9:0]  coin_val;
  logic [10:0] credit_sum;
  logic        coin_ok;
  logic [9:0]  price;

  always_comb begin
    coin_count = {1'b0, coin_q} + {1'b0, coin_d} + {1'b0, coin_n};
    coin_any   = coin_q | coin_d | coin_n;
    coin_val   = coin_q ? 10'd25 : (coin_d ? 10'd10 : 10'd5);
    // 11-bit sum so the ceiling compare cannot wrap
    credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
    coin_ok    = (coin_count == 2'd1) && (credit_sum <= 11'(MAX_CREDIT));
    case (sel_item)
      2'd0:    price = 10'(PRICE0);
      2'd1:    price = 10'(PRICE1);
      2'd2:    price = 10'(PRICE2);
      default: price = 10'(PRICE3);
    endcase
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    change_amt_d  = change_amt_q;
    timer_d       = timer_q;
    change_d      = change_q;
    disp_d        = 1'b0;
    vend_d        = 1'b0;
    vend_item_d   = vend_item_q;
    no_funds_d    = 1'b0;
    coin_reject_d = 1'b0;
    txn_done_d    = 1'b0;
    fault_d       = fault_q;

    case (state_q)
      ACCEPT: begin
        if (cancel && (credit_q != 10'd0)) begin
          change_amt_d  = credit_q;
          credit_d      = 10'd0;
          coin_reject_d = coin_any;
          state_d       = CHG_REQ;
        end else if (sel_valid && (credit_q >= price)) begin
          vend_d        = 1'b1;
          vend_item_d   = sel_item;
          change_amt_d  = credit_q - price;
          credit_d      = 10'd0;
          coin_reject_d = coin_any;
          if (credit_q == price) txn_done_d = 1'b1;
          else                   state_d    = CHG_REQ;
        end else begin
          // an unaffordable selection does not consume the coin slot
          no_funds_d = sel_valid;
          if (coin_ok) credit_d      = credit_sum[9:0];
          else         coin_reject_d = coin_any;
        end
      end
      CHG_REQ: begin
        coin_reject_d = coin_any;
        if (!disp_busy) begin
          disp_d   = 1'b1;
          change_d = change_amt_q;
          timer_d  = 8'd0;
          state_d  = CHG_WAIT;
        end
      end
      CHG_WAIT: begin
        coin_reject_d = coin_any;
        if (disp_done) begin
          txn_done_d = 1'b1;
          change_d   = 10'd0;
          state_d    = ACCEPT;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          fault_d  = 1'b1;
          change_d = 10'd0;
          state_d  = ACCEPT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = ACCEPT;
    endcase

    busy_d = (state_d != ACCEPT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ACCEPT;
      credit_q      <= 10'd0;
      change_amt_q  <= 10'd0;
      timer_q       <= 8'd0;
      change_q      <= 10'd0;
      disp_q        <= 1'b0;
      vend_q        <= 1'b0;
      vend_item_q   <= 2'd0;
      no_funds_q    <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
      txn_done_q    <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      change_amt_q  <= change_amt_d;
      timer_q       <= timer_d;
      change_q      <= change_d;
      disp_q        <= disp_d;
      vend_q        <= vend_d;
      vend_item_q   <= vend_item_d;
      no_funds_q    <= no_funds_d;
      coin_reject_q <= coin_reject_d;
      busy_q        <= busy_d;
      txn_done_q    <= txn_done_d;
      fault_q       <= fault_d;
    end
  end

  assign disp        = disp_q;
  assign change      = change_q;
  assign credit      = credit_q;
  assign vend        = vend_q;
  assign vend_item   = vend_item_q;
  assign no_funds    = no_funds_q;
  assign coin_reject = coin_reject_q;
  assign busy        = busy_q;
  assign txn_done    = txn_done_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed self-checking bench for vend_controller; the dispenser side is
// driven by hand inside each scenario task.
module tb_vend_controller;

  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_q = 1'b0, coin_d = 1'b0, coin_n = 1'b0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = 2'd0;
  logic       cancel = 1'b0;
  logic       disp_busy = 1'b0;
  logic       disp_done = 1'b0;
  logic       disp, vend, no_funds, coin_reject, busy, txn_done, fault;
  logic [9:0] change, credit;
  logic [1:0] vend_item;

  int checks = 0;
  int errors = 0;

  vend_controller #(
    .PRICE0(65), .PRICE1(100), .PRICE2(125), .PRICE3(150),
    .MAX_CREDIT(500), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .coin_q(coin_q), .coin_d(coin_d), .coin_n(coin_n),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
    .disp_busy(disp_busy), .disp_done(disp_done),
    .disp(disp), .change(change), .credit(credit),
    .vend(vend), .vend_item(vend_item), .no_funds(no_funds),
    .coin_reject(coin_reject), .busy(busy), .txn_done(txn_done), .fault(fault)
  );

  always #5 clk = ~clk;

  // advance one edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    coin_q = 0; coin_d = 0; coin_n = 0;
    sel_valid = 0; cancel = 0; disp_done = 0;
  endtask

  task automatic add_quarters(input int n);
    for (int i = 0; i < n; i++) begin
      coin_q = 1; tick(); coin_q = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    checks++;
    if ({disp, change, credit, vend, vend_item, no_funds, coin_reject, busy, txn_done, fault} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {disp, change, credit, vend, vend_item, no_funds, coin_reject, busy, txn_done, fault});
    end
    $display("test_reset: outputs idle");
  endtask

  task automatic test_vend_with_change();
    add_quarters(3);
    checks++; if (credit !== 10'd75) begin errors++; $display("FAIL credit75: got %0d, required 75", credit); end
    sel_valid = 1; sel_item = 2'd0; tick(); clear_inputs();
    checks++; if (vend !== 1'b1 || vend_item !== 2'd0) begin errors++; $display("FAIL vend0: got vend=%b item=%0d, required 1/0", vend, vend_item); end
    checks++; if (credit !== 10'd0 || busy !== 1'b1 || txn_done !== 1'b0) begin errors++; $display("FAIL vend0_state: got credit=%0d busy=%b done=%b, required 0/1/0", credit, busy, txn_done); end
    tick();
    checks++; if (disp !== 1'b1 || change !== 10'd10) begin errors++; $display("FAIL disp10: got disp=%b change=%0d, required 1/10", disp, change); end
    tick(); tick();
    checks++; if (disp !== 1'b0 || change !== 10'd10 || vend !== 1'b0) begin errors++; $display("FAIL hold10: got disp=%b change=%0d vend=%b, required 0/10/0", disp, change, vend); end
    disp_done = 1; tick(); clear_inputs();
    checks++; if (txn_done !== 1'b1 || change !== 10'd0 || busy !== 1'b0) begin errors++; $display("FAIL done10: got done=%b change=%0d busy=%b, required 1/0/0", txn_done, change, busy); end
    tick();
    checks++; if (txn_done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b, required 0", txn_done); end
    $display("test_vend_with_change: item 0, change 10");
  endtask

  task automatic test_exact_price();
    add_quarters(4);
    sel_valid = 1; sel_item = 2'd1; tick(); clear_inputs();
    checks++; if (vend !== 1'b1 || vend_item !== 2'd1 || txn_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL exact: got vend=%b item=%0d done=%b busy=%b, required 1/1/1/0", vend, vend_item, txn_done, busy); end
    tick();
    checks++; if (disp !== 1'b0 || busy !== 1'b0 || credit !== 10'd0) begin errors++; $display("FAIL exact_after: got disp=%b busy=%b credit=%0d, required 0/0/0", disp, busy, credit); end
    $display("test_exact_price: item 1, no change");
  endtask

  task automatic test_no_funds_cancel();
    add_quarters(2);
    sel_valid = 1; sel_item = 2'd2; tick(); clear_inputs();
    checks++; if (no_funds !== 1'b1 || credit !== 10'd50 || vend !== 1'b0) begin errors++; $display("FAIL no_funds: got nf=%b credit=%0d vend=%b, required 1/50/0", no_funds, credit, vend); end
    cancel = 1; tick(); clear_inputs();
    checks++; if (busy !== 1'b1 || credit !== 10'd0) begin errors++; $display("FAIL cancel: got busy=%b credit=%0d, required 1/0", busy, credit); end
    tick();
    checks++; if (disp !== 1'b1 || change !== 10'd50) begin errors++; $display("FAIL refund: got disp=%b change=%0d, required 1/50", disp, change); end
    disp_done = 1; tick(); clear_inputs();
    checks++; if (txn_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL refund_done: got done=%b busy=%b, required 1/0", txn_done, busy); end
    cancel = 1; tick(); clear_inputs();
    checks++; if (busy !== 1'b0 || disp !== 1'b0) begin errors++; $display("FAIL cancel_zero: got busy=%b disp=%b, required 0/0", busy, disp); end
    $display("test_no_funds_cancel: refund 50");
  endtask

  task automatic test_ceiling();
    add_quarters(20);
    checks++; if (credit !== 10'd500 || coin_reject !== 1'b0) begin errors++; $display("FAIL credit500: got credit=%0d rej=%b, required 500/0", credit, coin_reject); end
    coin_n = 1; tick(); clear_inputs();
    checks++; if (coin_reject !== 1'b1 || credit !== 10'd500) begin errors++; $display("FAIL over_ceiling: got rej=%b credit=%0d, required 1/500", coin_reject, credit); end
    coin_q = 1; coin_d = 1; tick(); clear_inputs();
    checks++; if (coin_reject !== 1'b1 || credit !== 10'd500) begin errors++; $display("FAIL multi_coin: got rej=%b credit=%0d, required 1/500", coin_reject, credit); end
    cancel = 1; tick(); clear_inputs(); tick();
    checks++; if (disp !== 1'b1 || change !== 10'd500) begin errors++; $display("FAIL refund500: got disp=%b change=%0d, required 1/500", disp, change); end
    disp_done = 1; tick(); clear_inputs();
    coin_d = 1; coin_n = 1; tick(); clear_inputs();
    checks++; if (coin_reject !== 1'b1 || credit !== 10'd0) begin errors++; $display("FAIL multi_low: got rej=%b credit=%0d, required 1/0", coin_reject, credit); end
    coin_d = 1; tick(); clear_inputs();
    checks++; if (credit !== 10'd10 || coin_reject !== 1'b0) begin errors++; $display("FAIL dime: got credit=%0d rej=%b, required 10/0", credit, coin_reject); end
    cancel = 1; tick(); clear_inputs(); tick();
    disp_done = 1; tick(); clear_inputs();
    $display("test_ceiling: 500 cap and multi-coin reject");
  endtask

  task automatic test_same_cycle_and_busy();
    add_quarters(3);
    sel_valid = 1; sel_item = 2'd0; coin_q = 1; tick(); clear_inputs();
    checks++; if (vend !== 1'b1 || coin_reject !== 1'b1 || credit !== 10'd0) begin errors++; $display("FAIL vend_coin: got vend=%b rej=%b credit=%0d, required 1/1/0", vend, coin_reject, credit); end
    disp_busy = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (disp !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL disp_wait%0d: got disp=%b busy=%b, required 0/1", i, disp, busy); end
    end
    disp_busy = 0; tick();
    checks++; if (disp !== 1'b1 || change !== 10'd10) begin errors++; $display("FAIL disp_after_busy: got disp=%b change=%0d, required 1/10", disp, change); end
    coin_d = 1; tick(); clear_inputs();
    checks++; if (coin_reject !== 1'b1 || credit !== 10'd0 || disp !== 1'b0) begin errors++; $display("FAIL wait_coin: got rej=%b credit=%0d disp=%b, required 1/0/0", coin_reject, credit, disp); end
    sel_valid = 1; sel_item = 2'd0; tick(); clear_inputs();
    checks++; if (vend !== 1'b0 || no_funds !== 1'b0 || busy !== 1'b1 || change !== 10'd10) begin errors++; $display("FAIL wait_sel: got vend=%b nf=%b busy=%b change=%0d, required 0/0/1/10", vend, no_funds, busy, change); end
    disp_done = 1; tick(); clear_inputs();
    checks++; if (txn_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL busy_done: got done=%b busy=%b, required 1/0", txn_done, busy); end
    $display("test_same_cycle_and_busy: coin rejected, disp deferred");
  endtask

  task automatic test_timeout_and_reset();
    int cnt;
    add_quarters(3);
    sel_valid = 1; sel_item = 2'd0; tick(); clear_inputs(); tick();
    checks++; if (disp !== 1'b1) begin errors++; $display("FAIL to_disp: got %b, required 1", disp); end
    cnt = 0;
    while (fault !== 1'b1 && cnt < TIMEOUT + 10) begin
      tick(); cnt++;
    end
    checks++; if (cnt !== TIMEOUT) begin errors++; $display("FAIL timeout_cycles: got %0d, required %0d", cnt, TIMEOUT); end
    checks++; if (busy !== 1'b0 || change !== 10'd0 || txn_done !== 1'b0) begin errors++; $display("FAIL timeout_state: got busy=%b change=%0d done=%b, required 0/0/0", busy, change, txn_done); end
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b, required 1", fault); end
    add_quarters(3);
    sel_valid = 1; sel_item = 2'd0; tick(); clear_inputs(); tick(); tick(); tick();
    rst = 1; tick(); rst = 0;
    checks++;
    if ({disp, change, credit, vend, vend_item, no_funds, coin_reject, busy, txn_done, fault} !== 29'd0) begin
      errors++;
      $display("FAIL mid_reset: got %b, required all zero",
               {disp, change, credit, vend, vend_item, no_funds, coin_reject, busy, txn_done, fault});
    end
    tick(); tick();
    checks++; if (disp !== 1'b0 || busy !== 1'b0 || credit !== 10'd0) begin errors++; $display("FAIL post_reset: got disp=%b busy=%b credit=%0d, required 0/0/0", disp, busy, credit); end
    $display("test_timeout_and_reset: fault after %0d cycles, cleared by rst", cnt);
  endtask

  initial begin
    test_reset();
    test_vend_with_change();
    test_exact_price();
    test_no_funds_cancel();
    test_ceiling();
    test_same_cycle_and_busy();
    test_timeout_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
